// File: rtl/sma_rr_scheduler.sv
// Round-robin front end for one shared registered sign-magnitude adder.
// It grants issue slots on credit, tracks the single in-flight lookup and returns tagged sums through a 2-entry buffer.
module sma_rr_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  output logic [DATA_WIDTH-1:0]          add_a,
  output logic [DATA_WIDTH-1:0]          add_b,
  input  logic [DATA_WIDTH:0]            add_sum,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH:0]            rsp_sum
);

  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic                  r_inflight;
  logic [ID_WIDTH-1:0]   r_inflight_id;
  logic [ID_WIDTH-1:0]   r_id  [2];
  logic [DATA_WIDTH:0]   r_sum [2];
  logic                  r_head;
  logic [1:0]            r_occ;

  logic                  w_pop;
  logic [2:0]            w_credit;
  logic                  w_issue_ok;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_idx;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_xfer;
  logic                  w_tail;

  assign rsp_valid = (r_occ != 2'd0);
  assign w_pop     = rsp_valid & rsp_ready;

  // Every issued lookup must already own a buffer slot when its sum lands.
  assign w_credit   = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue_ok = !reset && (w_credit < 3'd2);

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    w_gnt    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (w_issue_ok && w_found) w_gnt[w_gnt_id] = 1'b1;
  end

  assign req_ready = w_gnt;
  assign w_xfer    = w_issue_ok & w_found;
  assign add_a     = w_xfer ? req_a[w_gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign add_b     = w_xfer ? req_b[w_gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Credit check keeps occ <= 1 whenever a sum arrives, so the tail never collides.
  assign w_tail = r_head ^ r_occ[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr      <= ID_WIDTH'(NUM_REQ - 1);
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_head        <= 1'b0;
      r_occ         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_id[i]  <= '0;
        r_sum[i] <= '0;
      end
    end else begin
      r_inflight <= w_xfer;
      if (w_xfer) begin
        r_inflight_id <= w_gnt_id;
        r_rr_ptr      <= w_gnt_id;
      end
      if (r_inflight) begin
        r_id[w_tail]  <= r_inflight_id;
        r_sum[w_tail] <= add_sum;
      end
      if (w_pop) r_head <= ~r_head;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign rsp_id  = r_id[r_head];
  assign rsp_sum = r_sum[r_head];

endmodule
